wb_counter_slave: RTL and testbench



---
 rtl/wb_counter_pkg.sv | 31 +++
 rtl/wb_counter_prescaler.sv | 30 +++
 rtl/wb_counter_slave.sv | 152 +++++++++++++++
 tb/tb_wb_counter_slave.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_counter_pkg.sv
// Shared constants for the Wishbone counter peripheral.
// Holds the register offsets, the CTRL bit positions and the register-select decode.
package wb_counter_pkg;

  localparam logic [4:0] OffCtrl     = 5'h00;
  localparam logic [4:0] OffPrescale = 5'h04;
  localparam logic [4:0] OffCount    = 5'h08;
  localparam logic [4:0] OffCompare  = 5'h0C;
  localparam logic [4:0] OffStatus   = 5'h10;
  localparam logic [4:0] OffCapture  = 5'h14;

  localparam int unsigned CtrlEnBit         = 0;
  localparam int unsigned CtrlAutoReloadBit = 1;
  localparam int unsigned CtrlIrqEnBit      = 2;
  localparam int unsigned CtrlWidth         = 3;

  // COMPARE resets to all-ones, replicated to the data width.
  localparam logic CompareRstBit = 1'b1;

  typedef enum logic [2:0] {
    RegCtrl     = 3'(OffCtrl >> 2),
    RegPrescale = 3'(OffPrescale >> 2),
    RegCount    = 3'(OffCount >> 2),
    RegCompare  = 3'(OffCompare >> 2),
    RegStatus   = 3'(OffStatus >> 2),
    RegCapture  = 3'(OffCapture >> 2),
    RegRsvd6    = 3'd6,
    RegRsvd7    = 3'd7
  } reg_sel_e;

endpackage

// File: rtl/wb_counter_prescaler.sv
// Prescale divider: emits a tick every (i_prescale + 1) enabled cycles.
// Held at zero while disabled; i_clr restarts the division.
module wb_counter_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_en,
  input  logic                      i_clr,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_tick
);

  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic                      w_wrap;

  assign w_wrap = (r_cnt == i_prescale);
  assign o_tick = i_en & w_wrap;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/wb_counter_slave.sv
// Wishbone classic slave: prescaled up-counter with compare/match status and level IRQ.
// Define WB_COUNTER_CAPTURE_EN to add the read-only CAPTURE register at offset 0x14.
module wb_counter_slave
  import wb_counter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  input  logic                    wbs_we_i,
  input  logic [SELECT_WIDTH-1:0] wbs_sel_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  output logic                    wbs_ack_o,
  output logic                    wbs_err_o,
  output logic                    wbs_rty_o,
  output logic                    irq_o
);

  reg_sel_e                  w_reg;
  logic                      w_req, w_mapped, w_wr, w_tick, w_hit, w_cnt_wr, w_w1c, w_psc_clr;
  logic [DATA_WIDTH-1:0]     w_bmask, w_rdata;
  logic                      w_unused_adr;

  logic [CtrlWidth-1:0]      r_ctrl;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [DATA_WIDTH-1:0]     r_count, r_compare, r_dat;
  logic                      r_match, r_ack, r_err, r_irq;

  assign w_unused_adr = ^{wbs_adr_i[ADDR_WIDTH-1:5], wbs_adr_i[1:0]};

  assign w_reg     = reg_sel_e'(wbs_adr_i[4:2]);
  assign w_req     = wbs_cyc_i & wbs_stb_i & ~r_ack & ~r_err;
  assign w_wr      = w_req & w_mapped & wbs_we_i;
  assign w_cnt_wr  = w_wr & (w_reg == RegCount);
  assign w_psc_clr = w_wr & ((w_reg == RegCtrl) | (w_reg == RegPrescale));
  // A COUNT write in a tick cycle suppresses that tick's compare.
  assign w_hit     = w_tick & ~w_cnt_wr & (r_count == r_compare);
  assign w_w1c     = w_wr & (w_reg == RegStatus) & wbs_sel_i[0] & wbs_dat_i[0];

  always_comb begin
    w_bmask = '0;
    for (int i = 0; i < SELECT_WIDTH; i++) begin
      w_bmask[8*i +: 8] = {8{wbs_sel_i[i]}};
    end
  end

  wb_counter_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .i_en      (r_ctrl[CtrlEnBit]),
    .i_clr     (w_psc_clr),
    .i_prescale(r_prescale),
    .o_tick    (w_tick)
  );

`ifdef WB_COUNTER_CAPTURE_EN
  logic [DATA_WIDTH-1:0] r_capture;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_capture <= '0;
    end else if (w_hit) begin
      r_capture <= r_count;
    end
  end
`endif

  always_comb begin
    w_mapped = 1'b0;
    case (w_reg)
      RegCtrl, RegPrescale, RegCount, RegCompare, RegStatus: w_mapped = 1'b1;
`ifdef WB_COUNTER_CAPTURE_EN
      RegCapture: w_mapped = ~wbs_we_i;
`endif
      default: w_mapped = 1'b0;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      RegCtrl:     w_rdata[CtrlWidth-1:0] = r_ctrl;
      RegPrescale: w_rdata[PRESCALE_WIDTH-1:0] = r_prescale;
      RegCount:    w_rdata = r_count;
      RegCompare:  w_rdata = r_compare;
      RegStatus:   w_rdata[0] = r_match;
`ifdef WB_COUNTER_CAPTURE_EN
      RegCapture:  w_rdata = r_capture;
`endif
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dat      <= '0;
      r_irq      <= 1'b0;
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_count    <= '0;
      r_compare  <= {DATA_WIDTH{CompareRstBit}};
      r_match    <= 1'b0;
    end else begin
      r_ack <= w_req & w_mapped;
      r_err <= w_req & ~w_mapped;
      r_dat <= (w_req & w_mapped & ~wbs_we_i) ? w_rdata : '0;
      r_irq <= r_match & r_ctrl[CtrlIrqEnBit];

      if (w_wr && (w_reg == RegCtrl)) begin
        r_ctrl <= (r_ctrl & ~w_bmask[CtrlWidth-1:0]) | (wbs_dat_i[CtrlWidth-1:0] & w_bmask[CtrlWidth-1:0]);
      end
      if (w_wr && (w_reg == RegPrescale)) begin
        r_prescale <= (r_prescale & ~w_bmask[PRESCALE_WIDTH-1:0])
                    | (wbs_dat_i[PRESCALE_WIDTH-1:0] & w_bmask[PRESCALE_WIDTH-1:0]);
      end
      if (w_wr && (w_reg == RegCompare)) begin
        r_compare <= (r_compare & ~w_bmask) | (wbs_dat_i & w_bmask);
      end

      if (w_cnt_wr) begin
        r_count <= (r_count & ~w_bmask) | (wbs_dat_i & w_bmask);
      end else if (w_tick) begin
        r_count <= (w_hit && r_ctrl[CtrlAutoReloadBit]) ? '0 : r_count + DATA_WIDTH'(1);
      end

      // Set wins over a simultaneous W1C.
      if (w_hit) begin
        r_match <= 1'b1;
      end else if (w_w1c) begin
        r_match <= 1'b0;
      end
    end
  end

  assign wbs_dat_o = r_dat;
  assign wbs_ack_o = r_ack;
  assign wbs_err_o = r_err;
  assign wbs_rty_o = 1'b0;
  assign irq_o     = r_irq;

endmodule

// File: tb/tb_wb_counter_slave.sv
// Bench for wb_counter_slave: directed register checks plus randomized traffic
// compared every cycle against a register-map model of the peripheral.
module tb_wb_counter_slave;

`ifdef WB_COUNTER_CAPTURE_EN
  localparam bit Cap = 1'b1;
`else
  localparam bit Cap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] dat_o;
  logic        ack, err, rty, irq;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  wb_counter_slave dut (
    .clk      (clk),
    .rst      (rst),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_i),
    .wbs_dat_o(dat_o),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_ack_o(ack),
    .wbs_err_o(err),
    .wbs_rty_o(rty),
    .irq_o    (irq)
  );

  // Register-map model; m_el counts enabled cycles since the divider last restarted.
  logic [2:0]  m_ctrl = '0;
  logic [15:0] m_psc = '0;
  logic [31:0] m_count = '0, m_cmp = '1, m_cap = '0, m_dat = '0;
  logic        m_match = 1'b0, m_ack = 1'b0, m_err = 1'b0, m_irq = 1'b0;
  int unsigned m_el = 0;

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic        req, mapped, wr, tick, hit, cnt_wr;
    int          off;
    logic [31:0] rdv, mrg;
    if (!rst) begin
      m_ctrl = '0; m_psc = '0; m_count = '0; m_cmp = '1; m_cap = '0; m_match = 1'b0;
      m_el = 0; m_ack = 1'b0; m_err = 1'b0; m_dat = '0; m_irq = 1'b0;
    end else begin
      req    = cyc && stb && !m_ack && !m_err;
      off    = int'(adr[4:2]);
      mapped = (off < 5) || (Cap && off == 5 && !we);
      wr     = req && mapped && we;
      case (off)
        0:       rdv = {29'b0, m_ctrl};
        1:       rdv = {16'b0, m_psc};
        2:       rdv = m_count;
        3:       rdv = m_cmp;
        4:       rdv = {31'b0, m_match};
        5:       rdv = m_cap;
        default: rdv = '0;
      endcase
      mrg    = lanes(rdv, dat_i, sel);
      tick   = m_ctrl[0] && ((m_el % (m_psc + 1)) == m_psc);
      cnt_wr = wr && off == 2;
      hit    = tick && !cnt_wr && (m_count == m_cmp);

      m_irq = m_match && m_ctrl[2];
      m_ack = req && mapped;
      m_err = req && !mapped;
      m_dat = (req && mapped && !we) ? rdv : '0;
      m_el  = ((wr && off <= 1) || !m_ctrl[0]) ? 0 : m_el + 1;

      if (wr && off == 4 && sel[0] && dat_i[0]) m_match = 1'b0;
      if (hit) begin
        m_match = 1'b1;
        m_cap   = m_count;
      end
      if (cnt_wr) m_count = mrg;
      else if (tick) m_count = (hit && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
      if (wr && off == 0) m_ctrl = mrg[2:0];
      if (wr && off == 1) m_psc = mrg[15:0];
      if (wr && off == 3) m_cmp = mrg;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every DUT output against the model.
  task automatic step();
    @(negedge clk);
    if (chk_en) begin
      check("ack", 32'(ack), 32'(m_ack));
      check("err", 32'(err), 32'(m_err));
      check("dat_o", dat_o, m_dat);
      check("irq", 32'(irq), 32'(m_irq));
      check("rty", 32'(rty), 32'd0);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic ak,
                     output logic er, output int lat);
    adr = a; we = w; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
    step();
    lat = 1;
    while (!ack && !err && lat < 8) begin
      step();
      lat++;
    end
    rd = dat_o; ak = ack; er = err;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic ak, er;
    int l;
    bus(a, 1'b1, d, 4'hF, rd, ak, er, l);
    check("write ack", 32'(ak), 32'd1);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic ak, er;
    int l;
    bus(a, 1'b0, '0, 4'hF, rd, ak, er, l);
    check(nm, rd, exp);
    check({nm, " ack"}, 32'(ak), 32'd1);
    check({nm, " latency"}, 32'(l), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic        ak, er;
    int          l, acks;
    logic [31:0] wrap_exp [5];

    rst = 1'b0;
    step(); step();
    chk_en = 1'b1;
    step();
    rst = 1'b1;
    step();

    // Reset values and decode.
    rd_chk("rst CTRL", 32'h00, 32'h0);
    rd_chk("rst PRESCALE", 32'h04, 32'h0);
    rd_chk("rst COUNT", 32'h08, 32'h0);
    rd_chk("rst COMPARE", 32'h0C, 32'hFFFF_FFFF);
    rd_chk("rst STATUS", 32'h10, 32'h0);
    bus(32'h18, 1'b0, '0, 4'hF, d, ak, er, l);
    check("unmapped err", 32'(er), 32'd1);
    check("unmapped ack", 32'(ak), 32'd0);
    check("unmapped dat", d, 32'd0);

    // Divide by 4: ten ticks land before the read is sampled.
    wr(32'h04, 32'd3);
    wr(32'h00, 32'h1);
    repeat (40) step();
    bus(32'h08, 1'b0, '0, 4'hF, d, ak, er, l);
    check("prescale=3 count", d, 32'd10);

    // Match with autoreload and IRQ, then W1C byte-select behaviour.
    wr(32'h00, 32'h0);
    wr(32'h08, 32'h0);
    wr(32'h04, 32'h0);
    wr(32'h0C, 32'd5);
    wr(32'h10, 32'h1);
    wr(32'h00, 32'h7);
    for (int k = 0; k < 40 && !irq; k++) step();
    check("irq on match", 32'(irq), 32'd1);
    wr(32'h00, 32'h4);
    bus(32'h08, 1'b0, '0, 4'hF, d, ak, er, l);
    check("autoreload bound", 32'(d <= 32'd5), 32'd1);
    rd_chk("match STATUS", 32'h10, 32'h1);
    bus(32'h10, 1'b1, 32'h1, 4'h0, d, ak, er, l);
    check("w1c sel0 ack", 32'(ak), 32'd1);
    check("w1c sel0 irq kept", 32'(irq), 32'd1);
    bus(32'h10, 1'b1, 32'h1, 4'h1, d, ak, er, l);
    check("w1c irq dropped", 32'(irq), 32'd0);
    rd_chk("cleared STATUS", 32'h10, 32'h0);

    // Wrap through all-ones with a far compare value.
    wr(32'h00, 32'h0);
    wr(32'h0C, 32'h10);
    wr(32'h04, 32'd3);
    wr(32'h08, 32'hFFFF_FFFE);
    wr(32'h00, 32'h1);
    wrap_exp[0] = 32'hFFFF_FFFE; wrap_exp[1] = 32'hFFFF_FFFE;
    wrap_exp[2] = 32'hFFFF_FFFF; wrap_exp[3] = 32'hFFFF_FFFF; wrap_exp[4] = 32'h0;
    for (int k = 0; k < 5; k++) rd_chk("wrap COUNT", 32'h08, wrap_exp[k]);
    rd_chk("wrap STATUS", 32'h10, 32'h0);

    // COUNT write during a tick cycle loads the written value.
    wr(32'h04, 32'h0);
    wr(32'h08, 32'h1234);
    wr(32'h00, 32'h0);
    rd_chk("collide COUNT", 32'h08, 32'h1236);

    // No byte selects: acked but nothing written.
    bus(32'h00, 1'b1, 32'h7, 4'h0, d, ak, er, l);
    check("sel0 ack", 32'(ak), 32'd1);
    rd_chk("sel0 CTRL", 32'h00, 32'h0);

    // Strobe held for six cycles yields three responses.
    adr = 32'h08; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ack) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    step();
    check("held stb acks", 32'(acks), 32'd3);

`ifdef WB_COUNTER_CAPTURE_EN
    wr(32'h00, 32'h0);
    wr(32'h10, 32'h1);
    wr(32'h08, 32'h0);
    wr(32'h04, 32'h0);
    wr(32'h0C, 32'd7);
    wr(32'h00, 32'h3);
    repeat (20) step();
    wr(32'h00, 32'h0);
    rd_chk("CAPTURE", 32'h14, 32'd7);
    bus(32'h14, 1'b1, 32'h5, 4'hF, d, ak, er, l);
    check("CAPTURE write err", 32'(er), 32'd1);
    check("CAPTURE write ack", 32'(ak), 32'd0);
`else
    bus(32'h14, 1'b0, '0, 4'hF, d, ak, er, l);
    check("0x14 err", 32'(er), 32'd1);
    check("0x14 dat", d, 32'd0);
`endif

    // Randomized traffic, including dropped cycles and reset pulses.
    for (int i = 0; i < 4000; i++) begin
      int unsigned off;
      off = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0) off = $urandom_range(0, 5);
      rst = ($urandom_range(0, 399) != 0);
      cyc = ($urandom_range(0, 7) != 0);
      stb = ($urandom_range(0, 2) != 0);
      we  = 1'($urandom_range(0, 1));
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      adr = ($urandom & ~32'h1C) | (off << 2);
      case (off)
        0: begin
          dat_i = $urandom;
          if ($urandom_range(0, 3) != 0) dat_i[0] = 1'b1;
        end
        1: dat_i = $urandom_range(0, 3);
        2: dat_i = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                               : $urandom_range(0, 12);
        3: dat_i = $urandom_range(0, 12);
        default: dat_i = $urandom;
      endcase
      step();
    end
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
